// File: rtl/lcd_gdram_bus_receiver_if.sv
// ---------------------------------------------------------------------------
// lcd_gdram_bus_receiver_if
// Purpose : 8-bit parallel ST7920-style LCD write bus between a display
//           controller (master) and the GDRAM bus receiver (slave).
// Signals : lcd_rs   - 0 = instruction, 1 = data
//           lcd_rw   - 0 = write, 1 = read
//           lcd_en   - strobe, falling edge latches the bus
//           lcd_data - bus data byte
//           lcd_dout - status byte returned on reads   (BUSY_READ_EN only)
//           lcd_oe   - slave drives lcd_dout            (BUSY_READ_EN only)
// Config  : `define BUSY_READ_EN adds the read-back signals.
// ---------------------------------------------------------------------------
interface lcd_gdram_bus_receiver_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
`ifdef BUSY_READ_EN
  logic [7:0] lcd_dout;
  logic       lcd_oe;

  modport master (
    output lcd_rs, lcd_rw, lcd_en, lcd_data,
    input  lcd_dout, lcd_oe
  );

  modport slave (
    input  lcd_rs, lcd_rw, lcd_en, lcd_data,
    output lcd_dout, lcd_oe
  );
`else
  modport master (
    output lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport slave (
    input  lcd_rs, lcd_rw, lcd_en, lcd_data
  );
`endif
endinterface

// File: rtl/lcd_gdram_bus_receiver.sv
// ---------------------------------------------------------------------------
// lcd_gdram_bus_receiver
// Purpose : responder end of the ST7920-style parallel LCD write bus.
//           Synchronizes the bus into clk, detects qualified en falling
//           edges, decodes instruction bytes (function set, entry mode,
//           display control, clear, GDRAM Y/X address) and turns graphic
//           data bytes into writes to a 1024-byte 128x64 mono framebuffer
//           with ST7920 address auto-increment.
// Ports   : clk        50 MHz system clock
//           rst        asynchronous active-low reset
//           bus        LCD bus (slave modport)
//           fb_we      framebuffer write strobe, one clk wide
//           fb_addr    framebuffer byte address {y[4:0], x[3:0], hl}
//           fb_wdata   framebuffer write data
//           cmd_valid  one-clk pulse per accepted instruction byte
//           cmd_code   last accepted instruction byte
//           ext_mode   extended instruction set active (RE)
//           gfx_on     graphic display on (G)
//           disp_on    display on (D)
//           busy       clear sweep in progress
//           seq_err    one-clk pulse on a Y/X address-sequence violation
//           overrun    one-clk pulse when a write event is dropped while busy
// Config  : `define BUSY_READ_EN enables status reads on bus.lcd_dout /
//           bus.lcd_oe; without it reads are ignored.
// ---------------------------------------------------------------------------
module lcd_gdram_bus_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  lcd_gdram_bus_receiver_if.slave        bus,
  output logic                           fb_we,
  output logic [9:0]                     fb_addr,
  output logic [7:0]                     fb_wdata,
  output logic                           cmd_valid,
  output logic [7:0]                     cmd_code,
  output logic                           ext_mode,
  output logic                           gfx_on,
  output logic                           disp_on,
  output logic                           busy,
  output logic                           seq_err,
  output logic                           overrun
);

  localparam int CW = $clog2(MIN_EN_HIGH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_X = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  // synchronizer chains, index SYNC_STAGES-1 is the synchronized copy
  logic [SYNC_STAGES-1:0]      en_sync_r;
  logic [SYNC_STAGES-1:0]      rs_sync_r;
  logic [SYNC_STAGES-1:0]      rw_sync_r;
  logic [SYNC_STAGES-1:0][7:0] data_sync_r;

  logic          en_s;
  logic          rs_s;
  logic          rw_s;
  logic [7:0]    data_s;

  logic          en_prev_r;
  logic [CW-1:0] en_cnt_r;
  logic          fall_s;

  // registered bus event, one clk after the qualified falling edge
  logic          ev_valid_r;
  logic          ev_rs_r;
  logic          ev_rw_r;
  logic [7:0]    ev_data_r;
  logic          ev_wr_s;

  logic          is_fset_s;
  logic          is_clear_s;
  logic          is_disp_s;
  logic          is_gaddr_s;

  state_t        state_r;
  logic [4:0]    y_r;
  logic [3:0]    x_r;
  logic          hl_r;
  // bit 10 set marks the sweep as finished (all 1024 addresses written)
  logic [10:0]   clr_cnt_r;

  assign en_s   = en_sync_r[SYNC_STAGES-1];
  assign rs_s   = rs_sync_r[SYNC_STAGES-1];
  assign rw_s   = rw_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];

  // Only en pulses that stayed high for MIN_EN_HIGH synchronized cycles count.
  assign fall_s  = en_prev_r & ~en_s & (en_cnt_r == CW'(MIN_EN_HIGH));
  assign ev_wr_s = ev_valid_r & ~ev_rw_r;

  // Function set is common to both instruction sets; the rest depend on RE.
  assign is_fset_s  = (ev_data_r[7:5] == 3'b001);
  assign is_clear_s = ~ext_mode & (ev_data_r == 8'h01);
  assign is_disp_s  = ~ext_mode & (ev_data_r[7:3] == 5'b00001);
  assign is_gaddr_s = ext_mode & ev_data_r[7];

  // Bus input synchronizers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sync_r   <= '0;
      rs_sync_r   <= '0;
      rw_sync_r   <= '0;
      data_sync_r <= '0;
    end else begin
      en_sync_r   <= {en_sync_r[SYNC_STAGES-2:0], bus.lcd_en};
      rs_sync_r   <= {rs_sync_r[SYNC_STAGES-2:0], bus.lcd_rs};
      rw_sync_r   <= {rw_sync_r[SYNC_STAGES-2:0], bus.lcd_rw};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], bus.lcd_data};
    end
  end

  // En-high length counter, edge history and event capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_prev_r  <= 1'b0;
      en_cnt_r   <= '0;
      ev_valid_r <= 1'b0;
      ev_rs_r    <= 1'b0;
      ev_rw_r    <= 1'b0;
      ev_data_r  <= 8'h00;
    end else begin
      en_prev_r  <= en_s;
      if (!en_s) begin
        en_cnt_r <= '0;
      end else if (en_cnt_r != CW'(MIN_EN_HIGH)) begin
        en_cnt_r <= en_cnt_r + CW'(1);
      end
      ev_valid_r <= fall_s;
      if (fall_s) begin
        ev_rs_r   <= rs_s;
        ev_rw_r   <= rw_s;
        ev_data_r <= data_s;
      end
    end
  end

  // Decode FSM with registered outputs: GDRAM Y/X sequencing, data writes, clear sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      y_r       <= 5'd0;
      x_r       <= 4'd0;
      hl_r      <= 1'b0;
      clr_cnt_r <= 11'd0;
      fb_we     <= 1'b0;
      fb_addr   <= 10'd0;
      fb_wdata  <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'h00;
      ext_mode  <= 1'b0;
      gfx_on    <= 1'b0;
      disp_on   <= 1'b0;
      busy      <= 1'b0;
      seq_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fb_we     <= 1'b0;
      cmd_valid <= 1'b0;
      seq_err   <= 1'b0;
      overrun   <= 1'b0;
      case (state_r)
        CLEAR: begin
          // writes are dropped during the sweep; reads are legal status polls
          if (ev_wr_s) begin
            overrun <= 1'b1;
          end
          if (clr_cnt_r[10]) begin
            busy    <= 1'b0;
            state_r <= IDLE;
            y_r     <= 5'd0;
            x_r     <= 4'd0;
            hl_r    <= 1'b0;
          end else begin
            fb_we     <= 1'b1;
            fb_addr   <= clr_cnt_r[9:0];
            fb_wdata  <= 8'h00;
            clr_cnt_r <= clr_cnt_r + 11'd1;
          end
        end
        IDLE, WAIT_X: begin
          if (ev_wr_s) begin
            if (!ev_rs_r) begin
              cmd_valid <= 1'b1;
              cmd_code  <= ev_data_r;
            end
            if ((state_r == WAIT_X) && !ev_rs_r && is_gaddr_s) begin
              x_r     <= ev_data_r[3:0];
              hl_r    <= 1'b0;
              state_r <= IDLE;
            end else begin
              // a broken Y/X pair is flagged, then the byte is handled as if from IDLE
              if (state_r == WAIT_X) begin
                seq_err <= 1'b1;
                state_r <= IDLE;
              end
              if (!ev_rs_r) begin
                if (is_fset_s) begin
                  ext_mode <= ev_data_r[2];
                  if (ev_data_r[2]) begin
                    gfx_on <= ev_data_r[1];
                  end
                end else if (is_clear_s) begin
                  // first sweep write goes out together with busy
                  state_r   <= CLEAR;
                  busy      <= 1'b1;
                  fb_we     <= 1'b1;
                  fb_addr   <= 10'd0;
                  fb_wdata  <= 8'h00;
                  clr_cnt_r <= 11'd1;
                end else if (is_disp_s) begin
                  disp_on <= ev_data_r[2];
                end else if (is_gaddr_s) begin
                  y_r     <= ev_data_r[4:0];
                  hl_r    <= 1'b0;
                  state_r <= WAIT_X;
                end
              end else if (ext_mode) begin
                fb_we    <= 1'b1;
                fb_addr  <= {y_r, x_r, hl_r};
                fb_wdata <= ev_data_r;
                hl_r     <= ~hl_r;
                // x advances once per 16-bit word and wraps within the row
                if (hl_r) begin
                  x_r <= x_r + 4'd1;
                end
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef BUSY_READ_EN
  logic       oe_r;
  logic [7:0] dout_r;

  assign bus.lcd_oe   = oe_r;
  assign bus.lcd_dout = dout_r;

  // Status read-back: busy flag and current GDRAM row/half on instruction reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_r   <= 1'b0;
      dout_r <= 8'h00;
    end else begin
      oe_r <= ~rs_s & rw_s & en_s;
      if (rw_s && !rs_s) begin
        dout_r <= {busy, 1'b0, y_r, hl_r};
      end else begin
        dout_r <= 8'h00;
      end
    end
  end
`endif

endmodule

// File: doc/lcd_gdram_bus_receiver.md
Name: lcd_gdram_bus_receiver

Overview:
- Responder end of the 8-bit parallel ST7920-style LCD write bus driven by the team's block-display controllers.
- Samples rs/rw/en/data in the 50 MHz domain and decodes instruction bytes: function set, entry mode, display control, clear, and GDRAM Y/X address.
- Turns graphic data bytes into writes to a 1024-byte framebuffer (128x64 mono) with ST7920 address auto-increment.
- Used as a loopback display model for on-board self-check and as the bus checker in simulation.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on lcd_en, lcd_rs, lcd_rw and lcd_data (minimum 2).
- MIN_EN_HIGH, 4, minimum synchronized en-high length in clk cycles for a falling edge to count as a bus event.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous active-low reset
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- lcd_en  in  1  strobe; the falling edge latches the bus
- lcd_data  in  8  bus data
- fb_we  out  1  framebuffer write strobe, one clk wide
- fb_addr  out  10  framebuffer byte address = {y[4:0], x[3:0], hl}
- fb_wdata  out  8  framebuffer write data
- cmd_valid  out  1  one-clk pulse per accepted instruction byte
- cmd_code  out  8  last accepted instruction byte
- ext_mode  out  1  extended instruction set active (RE)
- gfx_on  out  1  graphic display on (G)
- disp_on  out  1  display on (D)
- busy  out  1  clear sweep in progress
- seq_err  out  1  one-clk pulse on an address-sequence violation
- overrun  out  1  one-clk pulse when a bus event is dropped during busy

Behaviour:
- Reset: every output is 0. Internal y, x, hl, the en-high counter and the FSM (state IDLE) are also 0. Reset asserted mid-operation aborts any clear sweep immediately.
- Front end:
  - All bus inputs pass through SYNC_STAGES flops.
  - The en-high counter saturates at MIN_EN_HIGH and clears while synchronized en is low.
  - An event is a synchronized 1->0 transition on en with counter == MIN_EN_HIGH. Shorter pulses are ignored silently.
  - rs and data are taken from the synchronized copies sampled in the same cycle as the falling edge.
- Latency: fb_we / cmd_valid assert exactly one clk after event detection, i.e. SYNC_STAGES+2 clk after the pin edge.
- rw=1 events are ignored: no output activity.
- Instruction decode (rs=0):
  - 001x_xRGx: function set in either mode; ext_mode=R (bit2), gfx_on=G (bit1), applied only when R=1.
  - When ext_mode=0:
    - 0x01: clear.
    - 0000_01xx: entry mode, recorded in cmd_code only.
    - 0000_1Dxx: disp_on=D.
    - 0x80-0xFF: DDRAM address, ignored.
  - When ext_mode=1, 1xxx_xxxx is a GDRAM address. Other extended codes are ignored.
  - cmd_valid pulses for every rs=0 write event, decoded or not.
- GDRAM address FSM (IDLE, WAIT_X):
  - In IDLE, an extended-mode address byte sets y = data[4:0] (bits 6:5 dropped), sets hl=0, and goes to WAIT_X.
  - In WAIT_X, an extended-mode address byte sets x = data[3:0] (bits 6:4 dropped), sets hl=0, and goes to IDLE.
  - In WAIT_X, any other event pulses seq_err, returns to IDLE, and is then processed normally in the same cycle.
- Data write (rs=1):
  - With ext_mode=1: fb_we=1, fb_addr={y,x,hl}, fb_wdata=data, then hl toggles. On hl 1->0, x increments and wraps 15->0; y is unchanged.
  - With ext_mode=0: the write is ignored.
- Clear (CLEAR state):
  - busy=1 and fb_we=1 every clk, addr 0..1023, wdata 0x00.
  - 1024 cycles, then busy=0 and y=x=hl=0.
  - Events during busy pulse overrun and are dropped.
  - A clear received in WAIT_X first pulses seq_err.

Optional Feature:
- BUSY_READ_EN
- Defined: adds ports lcd_dout[7:0] and lcd_oe.
  - lcd_oe is high while synchronized rs=0, rw=1 and en=1.
  - lcd_dout = {busy, 1'b0, y[4:0], hl}, registered.
  - rw=1, rs=1 reads return 0x00.
- Undefined: ports absent and reads ignored, as above.

Test Plan:
- Init 0x30,0x06,0x0C,0x36,0x80,0x80 then data 0xFF,0x00,0xAA:
  - disp_on=1, ext_mode=1, gfx_on=1.
  - Writes addr 0=0xFF, 1=0x00, 2=0xAA.
  - 6 cmd_valid pulses.
- 0x36, 0x85, 0x8F, data 0x11,0x22,0x33,0x44:
  - Writes at 190, 191, then 160, 161 (x wraps 15->0, y stays 5).
- MIN_EN_HIGH=4, rs=1 data 0x5A, en high 3 clk:
  - No fb_we.
  - Same with 4 clk: one write, latency SYNC_STAGES+2.
- 0x30, 0x01:
  - busy for 1024 clk, fb_we on every cycle, addr 0..1023 data 0.
  - An event at cycle 500: overrun pulse, no extra write.
  - rst low at cycle 700: all outputs 0 next cycle.
- 0x36, 0x84, then data 0x77:
  - seq_err pulse.
  - Write at {4,x_prev,0}.
  - FSM back in IDLE.
- With BUSY_READ_EN, read during clear:
  - lcd_oe=1, lcd_dout[7]=1.
  - After clear, lcd_dout=0x00.
